reg4x16_bank: RTL and testbench

- Four-entry, 16-bit register bank that sits directly downstream of the 16-bit 1:4 demux stage and stores the word the demux routes.
- A 2-bit select steers each write to one register through a one-hot load decode.
- The write side has a valid/ready handshake with a 2-entry skid buffer, so upstream can keep issuing while commits are held off.
- The read side is a registered single-port read with a one-cycle result pulse.

---
 rtl/reg4x16_bank_pkg.sv | 25 ++
 rtl/reg4x16_skid.sv | 65 ++++++
 rtl/reg4x16_bank.sv | 76 +++++++
 tb/tb_reg4x16_bank.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/reg4x16_bank_pkg.sv
// Shared definitions for the four-entry register bank.
//   WIDTH_DEF  : default data width of each register
//   SEL_W/NREG : register-index width and register count
//   SKID_DEF   : default write skid depth
//   skid_ent_t : one buffered write {sel, data}
//   onehot()   : register-index to load-enable decode
package reg4x16_bank_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int SEL_W     = 2;
   localparam int NREG      = 4;
   localparam int SKID_DEF  = 2;

   // Data field is sized from WIDTH_DEF; the bank's WIDTH parameter must match it.
   typedef struct packed {
      logic [SEL_W-1:0]     sel;
      logic [WIDTH_DEF-1:0] data;
   } skid_ent_t;

   function automatic logic [NREG-1:0] onehot(input logic [SEL_W-1:0] s);
      onehot    = '0;
      onehot[s] = 1'b1;
   endfunction

endpackage

// File: rtl/reg4x16_skid.sv
// Small write skid FIFO holding buffered, not-yet-committed writes.
//   clk, rst_n  : clock, async active-low reset (empties the FIFO)
//   push_i      : push push_ent_i at the tail (ignored when full)
//   pop_i       : pop the head (ignored when empty)
//   head_o      : current head entry
//   cnt_o       : number of stored entries
//   full_o      : cnt_o == SKID
module reg4x16_skid
   import reg4x16_bank_pkg::*;
#(
   parameter int SKID = SKID_DEF
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push_i,
   input  skid_ent_t push_ent_i,
   input  logic      pop_i,
   output skid_ent_t head_o,
   output logic [1:0] cnt_o,
   output logic      full_o
);

   localparam int PTR_W = (SKID > 1) ? $clog2(SKID) : 1;

   skid_ent_t        mem_q [SKID];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == 2'(SKID));
   assign cnt_o   = cnt_q;
   assign head_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & (cnt_q != 2'd0);

   // Pointers wrap explicitly so non-power-of-two depths also work.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) wr_ptr_d = (wr_ptr_q == PTR_W'(SKID-1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = (rd_ptr_q == PTR_W'(SKID-1)) ? '0 : rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < SKID; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (push_ok) mem_q[wr_ptr_q] <= push_ent_i;
      end
   end

endmodule

// File: rtl/reg4x16_bank.sv
// Four-entry register bank fed by a valid/ready write port with a skid
// buffer, plus a registered single-port read.
//   clk, rst_n            : clock, async active-low reset
//   wr_valid_i/wr_ready_o : write handshake; wr_sel_i/wr_data_i carried
//   hold_i                : blocks commits from the skid buffer this cycle
//   rd_req_i/rd_sel_i     : read request; result in rd_data_o with rd_valid_o pulse
//   ld_en_o               : one-hot load enable of the commit this cycle (0 if none)
//   pend_cnt_o            : buffered, uncommitted writes
module reg4x16_bank
   import reg4x16_bank_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SKID  = SKID_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid_i,
   output logic             wr_ready_o,
   input  logic [SEL_W-1:0] wr_sel_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             hold_i,
   input  logic             rd_req_i,
   input  logic [SEL_W-1:0] rd_sel_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             rd_valid_o,
   output logic [NREG-1:0]  ld_en_o,
   output logic [1:0]       pend_cnt_o
);

   skid_ent_t push_ent, head;
   logic      full, accept, commit;

   logic [NREG-1:0][WIDTH-1:0] reg_q, reg_d;
   logic [WIDTH-1:0]           rd_data_q, rd_data_d;
   logic                       rd_valid_q;

   assign push_ent   = '{sel: wr_sel_i, data: wr_data_i};
   // full comes straight from the registered count, never from wr_valid_i
   assign wr_ready_o = ~full;
   assign accept     = wr_valid_i & wr_ready_o;
   assign commit     = ~hold_i & (pend_cnt_o != 2'd0);
   assign ld_en_o    = commit ? onehot(head.sel) : '0;

   reg4x16_skid #(.SKID(SKID)) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (accept),
      .push_ent_i (push_ent),
      .pop_i      (commit),
      .head_o     (head),
      .cnt_o      (pend_cnt_o),
      .full_o     (full)
   );

   always_comb begin
      for (int i = 0; i < NREG; i++) reg_d[i] = ld_en_o[i] ? head.data : reg_q[i];
      // read from next-state so a same-edge commit is returned (write-first)
      rd_data_d = reg_d[rd_sel_i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         reg_q      <= reg_d;
         rd_valid_q <= rd_req_i;
         if (rd_req_i) rd_data_q <= rd_data_d;
      end
   end

   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_reg4x16_bank.sv
// Bench for reg4x16_bank: directed steps followed by random traffic, all
// compared against a queue/array reference model of the bank.
module tb_reg4x16_bank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid, wr_ready, hold, rd_req, rd_valid;
   logic [1:0]  wr_sel, rd_sel, pend_cnt;
   logic [15:0] wr_data, rd_data;
   logic [3:0]  ld_en;

   int nvec, nerr;

   typedef struct {
      logic [1:0]  sel;
      logic [15:0] data;
   } ent_t;

   ent_t        q[$];
   logic [15:0] mreg [4];
   logic        m_rv;
   logic [15:0] m_rd;

   always #5 clk = ~clk;

   reg4x16_bank dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_valid_i (wr_valid),
      .wr_ready_o (wr_ready),
      .wr_sel_i   (wr_sel),
      .wr_data_i  (wr_data),
      .hold_i     (hold),
      .rd_req_i   (rd_req),
      .rd_sel_i   (rd_sel),
      .rd_data_o  (rd_data),
      .rd_valid_o (rd_valid),
      .ld_en_o    (ld_en),
      .pend_cnt_o (pend_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 4; i++) mreg[i] = '0;
      m_rv = 1'b0;
      m_rd = '0;
   endtask

   // One clock: drive inputs, check handshake/commit outputs before the edge,
   // advance the model across the edge, then check the registered outputs.
   task automatic cyc(input logic v, input logic [1:0] s, input logic [15:0] d,
                      input logic h, input logic rq, input logic [1:0] rs);
      logic       acc, com;
      logic [3:0] exp_ld;
      wr_valid = v; wr_sel = s; wr_data = d; hold = h; rd_req = rq; rd_sel = rs;
      @(negedge clk);
      acc    = v && (q.size() < 2);
      com    = !h && (q.size() > 0);
      exp_ld = com ? (4'b0001 << q[0].sel) : 4'b0000;
      chk("wr_ready", 32'(wr_ready), 32'(q.size() < 2));
      chk("ld_en", 32'(ld_en), 32'(exp_ld));
      chk("pend_cnt_pre", 32'(pend_cnt), 32'(q.size()));
      @(posedge clk);
      if (com) begin
         mreg[q[0].sel] = q[0].data;
         void'(q.pop_front());
      end
      m_rv = rq;
      if (rq) m_rd = mreg[rs];
      if (acc) q.push_back('{sel: s, data: d});
      #1;
      chk("rd_valid", 32'(rd_valid), 32'(m_rv));
      chk("rd_data", 32'(rd_data), 32'(m_rd));
      chk("pend_cnt_post", 32'(pend_cnt), 32'(q.size()));
   endtask

   // Pulse reset in the middle of a cycle and check outputs clear at once.
   task automatic do_reset();
      wr_valid = 1'b0; hold = 1'b1; rd_req = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);
      chk("rst_pend_cnt", 32'(pend_cnt), 32'd0);
      chk("rst_ld_en", 32'(ld_en), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      model_reset();
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      nvec = 0; nerr = 0;
      rst_n = 1'b0;
      wr_valid = 0; wr_sel = 0; wr_data = 0; hold = 0; rd_req = 0; rd_sel = 0;
      model_reset();
      #7;
      chk("init_rd_valid", 32'(rd_valid), 32'd0);
      chk("init_wr_ready", 32'(wr_ready), 32'd1);
      chk("init_pend_cnt", 32'(pend_cnt), 32'd0);
      chk("init_rd_data", 32'(rd_data), 32'd0);
      #5 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // registers read back zero after reset
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0, 1, 2'(i));
         chk("rst_reg", 32'(rd_data), 32'h0000);
      end

      // basic write then read in the commit cycle
      cyc(1, 2, 16'hBEEF, 0, 0, 0);
      chk("basic_ld_en", 32'(ld_en), 32'b0100);
      cyc(0, 0, 0, 0, 1, 2);
      chk("basic_rd_data", 32'(rd_data), 32'hBEEF);
      chk("basic_rd_valid", 32'(rd_valid), 32'd1);

      // backpressure under hold from a clean bank
      do_reset();
      cyc(1, 0, 16'h1111, 1, 0, 0);
      cyc(1, 1, 16'h2222, 1, 0, 0);
      chk("bp_pend_full", 32'(pend_cnt), 32'd2);
      chk("bp_not_ready", 32'(wr_ready), 32'd0);
      cyc(1, 3, 16'h3333, 1, 0, 0);
      cyc(1, 3, 16'h3333, 0, 0, 0);
      chk("bp_ready_back", 32'(wr_ready), 32'd1);
      cyc(1, 3, 16'h3333, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0); chk("bp_reg0", 32'(rd_data), 32'h1111);
      cyc(0, 0, 0, 0, 1, 1); chk("bp_reg1", 32'(rd_data), 32'h2222);
      cyc(0, 0, 0, 0, 1, 2); chk("bp_reg2", 32'(rd_data), 32'h0000);
      cyc(0, 0, 0, 0, 1, 3); chk("bp_reg3", 32'(rd_data), 32'h3333);

      // same-index ordering: later write wins
      cyc(1, 1, 16'hAAAA, 0, 0, 0);
      chk("ord_ld_en0", 32'(ld_en), 32'b0010);
      cyc(1, 1, 16'h5555, 0, 0, 0);
      chk("ord_ld_en1", 32'(ld_en), 32'b0010);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1);
      chk("ord_reg1", 32'(rd_data), 32'h5555);

      // read collides with commit to the same register
      cyc(1, 3, 16'hCAFE, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 3);
      chk("coll_rd_data", 32'(rd_data), 32'hCAFE);

      // reset discards buffered writes
      cyc(1, 0, 16'hDEAD, 1, 0, 0);
      cyc(1, 2, 16'hF00D, 1, 0, 0);
      chk("mid_pend_full", 32'(pend_cnt), 32'd2);
      do_reset();
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0, 1, 2'(i));
         chk("mid_reg_clear", 32'(rd_data), 32'h0000);
      end

      // random traffic against the model
      for (int n = 0; n < 400; n++) begin
         cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom()),
             ($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
